// File: rtl/vram_access_ctrl.sv
// Single-bank VRAM initiator: arbitrates a level-handshake CPU port against
// a pulse-request video fetch port, alternating grants whenever both are waiting.
module vram_access_ctrl #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          i_MCLK,
  input  logic          i_RST,
  input  logic          i_CPU_REQ,
  input  logic          i_CPU_WE,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [DW-1:0] i_CPU_DIN,
  output logic          o_CPU_ACK,
  output logic [DW-1:0] o_CPU_DOUT,
  input  logic          i_VID_REQ,
  input  logic [AW-1:0] i_VID_ADDR,
  output logic [DW-1:0] o_VID_DOUT,
  output logic          o_VID_VALID,
  output logic [AW-1:0] o_SRAM_ADDR,
  output logic [DW-1:0] o_SRAM_DIN,
  output logic          o_SRAM_WR_n,
  output logic          o_SRAM_RD_n,
  input  logic [DW-1:0] i_SRAM_DOUT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VID_RD  = 3'd1,
    VID_CAP = 3'd2,
    CPU_RD  = 3'd3,
    CPU_CAP = 3'd4,
    CPU_WR  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          vid_pend_q, vid_pend_d;
  logic [AW-1:0] vid_addr_q, vid_addr_d;
  logic          last_vid_q, last_vid_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [DW-1:0] sram_din_q, sram_din_d;
  logic          wr_n_q, wr_n_d;
  logic          rd_n_q, rd_n_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic [DW-1:0] vid_dout_q, vid_dout_d;
  logic          vid_valid_q, vid_valid_d;
  logic          cpu_ok_s;

  // Next-state, arbitration and output-register update
  always_comb begin
    state_d     = state_q;
    vid_pend_d  = vid_pend_q;
    vid_addr_d  = vid_addr_q;
    last_vid_d  = last_vid_q;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    wr_n_d      = wr_n_q;
    rd_n_d      = rd_n_q;
    cpu_dout_d  = cpu_dout_q;
    vid_dout_d  = vid_dout_q;
    vid_valid_d = 1'b0;
    cpu_ack_d   = cpu_ack_q & i_CPU_REQ;
    cpu_ok_s    = i_CPU_REQ & ~cpu_ack_q;

    case (state_q)
      IDLE: begin
        if (vid_pend_q && (!cpu_ok_s || !last_vid_q)) begin
          sram_addr_d = vid_addr_q;
          rd_n_d      = 1'b0;
          vid_pend_d  = 1'b0;
          last_vid_d  = 1'b1;
          state_d     = VID_RD;
        end else if (cpu_ok_s) begin
          sram_addr_d = i_CPU_ADDR;
          last_vid_d  = 1'b0;
          if (i_CPU_WE) begin
            sram_din_d = i_CPU_DIN;
            wr_n_d     = 1'b0;
            state_d    = CPU_WR;
          end else begin
            rd_n_d  = 1'b0;
            state_d = CPU_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      VID_RD: begin
        rd_n_d  = 1'b1;
        state_d = VID_CAP;
      end
      VID_CAP: begin
        vid_dout_d  = i_SRAM_DOUT;
        vid_valid_d = 1'b1;
        state_d     = IDLE;
      end
      CPU_RD: begin
        rd_n_d  = 1'b1;
        state_d = CPU_CAP;
      end
      CPU_CAP: begin
        cpu_dout_d = i_SRAM_DOUT;
        cpu_ack_d  = 1'b1;
        state_d    = IDLE;
      end
      CPU_WR: begin
        wr_n_d    = 1'b1;
        cpu_ack_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        wr_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Evaluated after the accept so a pulse on the accept edge stays pending
    if (i_VID_REQ) begin
      vid_pend_d = 1'b1;
      vid_addr_d = i_VID_ADDR;
    end else begin
      vid_addr_d = vid_addr_q;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= IDLE;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= {AW{1'b0}};
      last_vid_q  <= 1'b0;
      sram_addr_q <= {AW{1'b0}};
      sram_din_q  <= {DW{1'b0}};
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      cpu_dout_q  <= {DW{1'b0}};
      vid_dout_q  <= {DW{1'b0}};
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vid_pend_q  <= vid_pend_d;
      vid_addr_q  <= vid_addr_d;
      last_vid_q  <= last_vid_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_dout_q  <= vid_dout_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  assign o_CPU_ACK   = cpu_ack_q;
  assign o_CPU_DOUT  = cpu_dout_q;
  assign o_VID_DOUT  = vid_dout_q;
  assign o_VID_VALID = vid_valid_q;
  assign o_SRAM_ADDR = sram_addr_q;
  assign o_SRAM_DIN  = sram_din_q;
  assign o_SRAM_WR_n = wr_n_q;
  assign o_SRAM_RD_n = rd_n_q;

endmodule

// File: tb/tb_vram_access_ctrl.sv
// Directed bench for vram_access_ctrl with a registered-read RAM model and
// queue scoreboards for CPU read data and video fetch data.
module tb_vram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_addr = 12'h000;
  logic [7:0]  cpu_din = 8'h00;
  logic        cpu_ack;
  logic [7:0]  cpu_dout;
  logic        vid_req = 1'b0;
  logic [11:0] vid_addr = 12'h000;
  logic [7:0]  vid_dout;
  logic        vid_valid;
  logic [11:0] sram_addr;
  logic [7:0]  sram_din;
  logic        sram_wr_n, sram_rd_n;
  logic [7:0]  sram_dout = 8'h00;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  mem   [4096];
  logic        wrote [4096];

  logic [7:0]  cpu_q [$];
  logic [7:0]  vid_q [$];
  bit          grant_q [$];
  bit          vid_mode = 1'b0;
  logic [7:0]  vid_const_exp = 8'h77;

  int          rd_cnt = 0, wr_cnt = 0, acc_cyc = 0;
  bit          acc_wr = 1'b0;
  bit          prev_rd_low = 1'b0, prev_wr_low = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0;
  logic [11:0] last_rd_addr = 12'h000, last_wr_addr = 12'h000;
  logic [7:0]  last_wr_din = 8'h00;

  vram_access_ctrl #(.AW(12), .DW(8)) dut (
    .i_MCLK(clk), .i_RST(rst),
    .i_CPU_REQ(cpu_req), .i_CPU_WE(cpu_we), .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
    .o_CPU_ACK(cpu_ack), .o_CPU_DOUT(cpu_dout),
    .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr), .o_VID_DOUT(vid_dout), .o_VID_VALID(vid_valid),
    .o_SRAM_ADDR(sram_addr), .o_SRAM_DIN(sram_din), .o_SRAM_WR_n(sram_wr_n),
    .o_SRAM_RD_n(sram_rd_n), .i_SRAM_DOUT(sram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [11:0] a);
    case (a)
      12'h123: init_val = 8'h5A;
      12'h010: init_val = 8'h11;
      12'h020: init_val = 8'h22;
      12'h8AA: init_val = 8'h77;
      default: init_val = a[7:0] ^ 8'h3C;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM model: registered read, write on the edge that sees WR_n low
  always @(posedge clk) begin
    if (!sram_wr_n) begin
      mem[sram_addr]   <= sram_din;
      wrote[sram_addr] <= 1'b1;
    end
    if (!sram_rd_n) sram_dout <= wrote[sram_addr] ? mem[sram_addr] : init_val(sram_addr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: strobe widths, latencies and scoreboard pops
  always @(negedge clk) begin
    if (rst) begin
      prev_rd_low = 1'b0; prev_wr_low = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0;
    end else begin
      if (!sram_rd_n || !sram_wr_n) chk("rd_wr_exclusive", 32'(sram_rd_n | sram_wr_n), 32'd1);
      if (!sram_rd_n) begin
        chk("rd_pulse_width", 32'(prev_rd_low), 32'd0);
        rd_cnt++; acc_cyc = cyc; acc_wr = 1'b0; last_rd_addr = sram_addr;
        grant_q.push_back(sram_addr[11]);
      end
      if (!sram_wr_n) begin
        chk("wr_pulse_width", 32'(prev_wr_low), 32'd0);
        wr_cnt++; acc_cyc = cyc; acc_wr = 1'b1; last_wr_addr = sram_addr; last_wr_din = sram_din;
        grant_q.push_back(sram_addr[11]);
      end
      if (vid_valid) begin
        chk("valid_latency", 32'(cyc - acc_cyc), 32'd2);
        chk("valid_width", 32'(prev_valid), 32'd0);
        if (vid_mode) chk("vid_data_const", 32'(vid_dout), 32'(vid_const_exp));
        else if (vid_q.size() > 0) chk("vid_data", 32'(vid_dout), 32'(vid_q.pop_front()));
        else chk("vid_sb_underflow", 32'd0, 32'd1);
      end
      if (cpu_ack && !prev_ack) begin
        chk("ack_latency", 32'(cyc - acc_cyc), acc_wr ? 32'd1 : 32'd2);
        if (!acc_wr) begin
          if (cpu_q.size() > 0) chk("cpu_rdata", 32'(cpu_dout), 32'(cpu_q.pop_front()));
          else chk("cpu_sb_underflow", 32'd0, 32'd1);
        end
      end
      prev_rd_low = !sram_rd_n; prev_wr_low = !sram_wr_n;
      prev_ack = cpu_ack; prev_valid = vid_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 20; i++) begin
      if (cpu_ack) break;
      tick(1);
    end
    chk("ack_seen", 32'(cpu_ack), 32'd1);
  endtask

  // One complete CPU access from an idle controller; inputs are scrambled after accept
  task automatic cpu_op(input logic we, input logic [11:0] a, input logic [7:0] d);
    cpu_we = we; cpu_addr = a; cpu_din = d; cpu_req = 1'b1;
    if (!we) cpu_q.push_back(d);
    tick(1);
    chk("cpu_accept", 32'(we ? sram_wr_n : sram_rd_n), 32'd0);
    cpu_we = ~we; cpu_addr = ~a; cpu_din = ~d;
    wait_ack();
    cpu_req = 1'b0;
    tick(1);
    chk("ack_release", 32'(cpu_ack), 32'd0);
  endtask

  initial begin
    int rd0, wr0, g0, lows;
    rst = 1'b1;
    tick(2);
    chk("rst_wr_n", 32'(sram_wr_n), 32'd1);
    chk("rst_rd_n", 32'(sram_rd_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_din", 32'(sram_din), 32'd0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    chk("rst_valid", 32'(vid_valid), 32'd0);
    chk("rst_vid_dout", 32'(vid_dout), 32'd0);
    rst = 1'b0;
    tick(2);

    // Single video fetch of 0x123
    wr0 = wr_cnt;
    vid_req = 1'b1; vid_addr = 12'h123; vid_q.push_back(8'h5A);
    tick(1);
    vid_req = 1'b0; vid_addr = 12'h000;
    tick(6);
    chk("vid_rd_addr", 32'(last_rd_addr), 32'h123);
    chk("vid_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("vid_dout_hold", 32'(vid_dout), 32'h5A);
    chk("vid_sb_empty", 32'(vid_q.size()), 32'd0);

    // CPU write then read at the top of the address space
    cpu_op(1'b1, 12'hFFF, 8'hA5);
    chk("wr_addr", 32'(last_wr_addr), 32'hFFF);
    chk("wr_din", 32'(last_wr_din), 32'hA5);
    cpu_op(1'b0, 12'hFFF, 8'hA5);
    chk("rd_dout_hold", 32'(cpu_dout), 32'hA5);

    // Read request held for 20 cycles after ACK
    rd0 = rd_cnt;
    cpu_we = 1'b0; cpu_addr = 12'h055; cpu_req = 1'b1; cpu_q.push_back(init_val(12'h055));
    tick(1);
    wait_ack();
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!cpu_ack) lows++;
    end
    chk("ack_held", 32'(lows), 32'd0);
    chk("held_one_access", 32'(rd_cnt - rd0), 32'd1);
    cpu_req = 1'b0;
    tick(1);
    chk("held_ack_release", 32'(cpu_ack), 32'd0);
    tick(2);

    // Contention: both pending at one arbitration edge, then continuous demand
    g0 = grant_q.size();
    vid_mode = 1'b1;
    cpu_we = 1'b0;
    for (int k = 0; k < 40; k++) begin
      vid_req = 1'b1; vid_addr = 12'h8AA;
      if (k > 0) begin
        if (cpu_req && cpu_ack) cpu_req = 1'b0;
        else if (!cpu_req && !cpu_ack) begin
          cpu_req = 1'b1; cpu_addr = 12'h040 + 12'(k);
          cpu_q.push_back(init_val(12'h040 + 12'(k)));
        end
      end
      tick(1);
    end
    vid_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cpu_req && cpu_ack) cpu_req = 1'b0;
      tick(1);
    end
    vid_mode = 1'b0;
    chk("grant_count", 32'(grant_q.size() - g0 >= 10), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (g0 + i < grant_q.size())
        chk($sformatf("grant_%0d", i), 32'(grant_q[g0 + i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("contention_cpu_sb_empty", 32'(cpu_q.size()), 32'd0);

    // Two video pulses while a CPU read is in flight collapse into one fetch
    rd0 = rd_cnt;
    cpu_we = 1'b0; cpu_addr = 12'h066; cpu_req = 1'b1; cpu_q.push_back(init_val(12'h066));
    tick(1);
    vid_req = 1'b1; vid_addr = 12'h010;
    tick(1);
    vid_addr = 12'h020; vid_q.push_back(8'h22);
    tick(1);
    vid_req = 1'b0; vid_addr = 12'h000;
    wait_ack();
    cpu_req = 1'b0;
    tick(8);
    chk("coalesce_rd_count", 32'(rd_cnt - rd0), 32'd2);
    chk("coalesce_addr", 32'(last_rd_addr), 32'h020);
    chk("coalesce_vid_dout", 32'(vid_dout), 32'h22);

    // Reset asserted while WR_n is low
    wr0 = wr_cnt;
    cpu_we = 1'b1; cpu_addr = 12'h0AB; cpu_din = 8'h99; cpu_req = 1'b1;
    tick(1);
    chk("midrst_wr_low", 32'(sram_wr_n), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_wr_n", 32'(sram_wr_n), 32'd1);
    chk("midrst_rd_n", 32'(sram_rd_n), 32'd1);
    chk("midrst_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("midrst_no_ack", 32'(cpu_ack), 32'd0);
    cpu_op(1'b1, 12'h0AB, 8'h3C);
    chk("postrst_wr_din", 32'(last_wr_din), 32'h3C);
    cpu_op(1'b0, 12'h0AB, 8'h3C);
    chk("postrst_wr_count", 32'(wr_cnt - wr0), 32'd1);

    tick(4);
    chk("final_cpu_sb_empty", 32'(cpu_q.size()), 32'd0);
    chk("final_vid_sb_empty", 32'(vid_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
